// File: rtl/wb_display_driver.sv
// wb_display_driver
//
// Captures the CPU debug outputs (fetch PC and write-back data) on a strobe
// and scans them onto an 8-digit common-anode seven-segment display.
// Digits 7..4 show PC[15:0], digits 3..0 show WriteData[15:0]; digit 0 is
// the rightmost. Each digit owns REFRESH_DIV cycles, the first BLANK_CYCLES
// of which drive all digits off so the previous digit's segments do not
// ghost onto the next one.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      asynchronous, active-high reset
//   PCResult   fetch-stage PC (only [15:0] used)
//   WriteData  write-back value (only [15:0] used)
//   sample     one-cycle snapshot strobe
//   freeze     holds the snapshots while high (wins over sample)
//   out7       segments, active-low, {g,f,e,d,c,b,a}
//   en_out     digit enables, active-low, en_out[i] drives digit i

module wb_display_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  input  logic [31:0] WriteData,
  input  logic        sample,
  input  logic        freeze,
  output logic [6:0]  out7,
  output logic [7:0]  en_out
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [15:0]   pc_snap_q, pc_snap_d;
  logic [15:0]   wd_snap_q, wd_snap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    en_out_q, en_out_d;
  logic [6:0]    out7_q, out7_d;

  logic          blank;
  logic [15:0]   snap_sel;
  logic [3:0]    nib;

  // Upper halves of the debug buses are not displayed.
  logic unused_hi;
  assign unused_hi = ^{PCResult[31:16], WriteData[31:16]};

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // With no blanking configured the compare would be against zero, so
  // tie it off instead of building a constant-false comparator.
  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign blank = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
      assign blank = (cnt_q < BLANK_C);
    end
  endgenerate

  // Snapshot capture; freeze has priority over sample.
  always_comb begin
    pc_snap_d = pc_snap_q;
    wd_snap_d = wd_snap_q;
    if (sample && !freeze) begin
      pc_snap_d = PCResult[15:0];
      wd_snap_d = WriteData[15:0];
    end
  end

  // Refresh counter and digit scanner; idx wraps 7 -> 0 by width.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // idx[2] picks PC (upper four digits) or WriteData, idx[1:0] the nibble.
  always_comb begin
    snap_sel = idx_q[2] ? pc_snap_q : wd_snap_q;
    case (idx_q[1:0])
      2'd0:    nib = snap_sel[3:0];
      2'd1:    nib = snap_sel[7:4];
      2'd2:    nib = snap_sel[11:8];
      default: nib = snap_sel[15:12];
    endcase
  end

  always_comb begin
    en_out_d = 8'hFF;
    out7_d   = 7'h7F;
    if (!blank) begin
      en_out_d = ~(8'b1 << idx_q);
      out7_d   = hex7(nib);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_snap_q <= '0;
      wd_snap_q <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      en_out_q  <= 8'hFF;
      out7_q    <= 7'h7F;
    end else begin
      pc_snap_q <= pc_snap_d;
      wd_snap_q <= wd_snap_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      en_out_q  <= en_out_d;
      out7_q    <= out7_d;
    end
  end

  assign en_out = en_out_q;
  assign out7   = out7_q;

endmodule
